// File: rtl/seg_scanner.sv
// rtl/seg_scanner.sv - four-digit multiplexed seven-segment scanner with blanking gaps and a frame-aligned load buffer
module seg_scanner #(
    parameter int BLANK_CYCLES = 2,
    parameter int HEX_MODE     = 1
) (
    input  logic        MasterClock,
    input  logic        Reset_n,
    input  logic        ScanTick,
    input  logic [15:0] Value,
    input  logic [3:0]  DpMask,
    input  logic        BlankZeros,
    input  logic        LoadValid,
    output logic        LoadReady,
    output logic [3:0]  Anode,
    output logic [6:0]  Segment,
    output logic        Dp
);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

    localparam logic [7:0] LP_CNT_INIT = 8'(BLANK_CYCLES - 1);
    localparam logic [6:0] LP_SEG_OFF  = 7'h7F;

    state_t      r_state;
    logic [1:0]  r_idx;
    logic [7:0]  r_cnt;
    logic [15:0] r_disp_val;
    logic [3:0]  r_disp_dp;
    logic [15:0] r_pend_val;
    logic [3:0]  r_pend_dp;
    logic        r_pend_full;
    logic [3:0]  r_anode;
    logic [6:0]  r_seg;
    logic        r_dp;

    logic        w_tick_acc;
    logic [1:0]  w_next_idx;
    logic        w_commit;
    logic        w_load;
    logic [3:0]  w_nib;
    logic        w_lead_zero;
    logic [6:0]  w_seg_show;

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] seg;
        seg = LP_SEG_OFF;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = LP_SEG_OFF;
        endcase
        if (HEX_MODE == 0 && nib > 4'd9) seg = LP_SEG_OFF;
        return seg;
    endfunction

    // Ticks landing inside the blanking gap are dropped entirely.
    assign w_tick_acc = ScanTick && (r_state != S_BLANK);
    assign w_next_idx = r_idx + 2'd1;
    assign w_commit   = w_tick_acc && (w_next_idx == 2'd0) && r_pend_full;
    assign w_load     = LoadValid && !r_pend_full;
    assign w_nib      = r_disp_val[{r_idx, 2'b00} +: 4];
    assign LoadReady  = !r_pend_full;

    always_comb begin
        w_lead_zero = 1'b0;
        case (r_idx)
            2'd3:    w_lead_zero = (r_disp_val[15:12] == 4'd0);
            2'd2:    w_lead_zero = (r_disp_val[15:8] == 8'd0);
            2'd1:    w_lead_zero = (r_disp_val[15:4] == 12'd0);
            default: w_lead_zero = 1'b0;
        endcase
        w_lead_zero = w_lead_zero && BlankZeros;
    end

    assign w_seg_show = w_lead_zero ? LP_SEG_OFF : f_decode(w_nib);

    always_ff @(posedge MasterClock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= S_IDLE;
            r_idx       <= 2'd3;
            r_cnt       <= 8'd0;
            r_disp_val  <= 16'd0;
            r_disp_dp   <= 4'd0;
            r_pend_val  <= 16'd0;
            r_pend_dp   <= 4'd0;
            r_pend_full <= 1'b0;
            r_anode     <= 4'b1111;
            r_seg       <= LP_SEG_OFF;
            r_dp        <= 1'b1;
        end else begin
            // Load and commit never coincide: a load needs an empty buffer, a commit a full one.
            if (w_load) begin
                r_pend_val  <= Value;
                r_pend_dp   <= DpMask;
                r_pend_full <= 1'b1;
            end
            if (w_commit) begin
                r_disp_val  <= r_pend_val;
                r_disp_dp   <= r_pend_dp;
                r_pend_full <= 1'b0;
            end
            case (r_state)
                S_IDLE, S_SHOW: begin
                    if (w_tick_acc) begin
                        r_state <= S_BLANK;
                        r_idx   <= w_next_idx;
                        r_cnt   <= LP_CNT_INIT;
                        r_anode <= 4'b1111;
                        r_seg   <= LP_SEG_OFF;
                        r_dp    <= 1'b1;
                    end
                end
                S_BLANK: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= S_SHOW;
                        r_anode <= ~(4'b0001 << r_idx);
                        r_seg   <= w_seg_show;
                        r_dp    <= ~r_disp_dp[r_idx];
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Anode   = r_anode;
    assign Segment = r_seg;
    assign Dp      = r_dp;

endmodule

// File: tb/tb_seg_scanner.sv
// tb/tb_seg_scanner.sv - random and directed stimulus for seg_scanner checked against a timing-based reference model
module tb_seg_scanner;

    localparam int NDUT = 2;
    localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        ScanTick = 1'b0;
    logic [15:0] Value = 16'd0;
    logic [3:0]  DpMask = 4'd0;
    logic        BlankZeros = 1'b0;
    logic        LoadValid = 1'b0;

    logic        rdy0, rdy1, dp0, dp1;
    logic [3:0]  an0, an1;
    logic [6:0]  seg0, seg1;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    seg_scanner #(.BLANK_CYCLES(2), .HEX_MODE(1)) dut_hex (
        .MasterClock(clk), .Reset_n(Reset_n), .ScanTick(ScanTick), .Value(Value), .DpMask(DpMask),
        .BlankZeros(BlankZeros), .LoadValid(LoadValid), .LoadReady(rdy0), .Anode(an0),
        .Segment(seg0), .Dp(dp0)
    );

    seg_scanner #(.BLANK_CYCLES(3), .HEX_MODE(0)) dut_dec (
        .MasterClock(clk), .Reset_n(Reset_n), .ScanTick(ScanTick), .Value(Value), .DpMask(DpMask),
        .BlankZeros(BlankZeros), .LoadValid(LoadValid), .LoadReady(rdy1), .Anode(an1),
        .Segment(seg1), .Dp(dp1)
    );

    // Reference model: tracks the edge of the last honoured tick and derives outputs from elapsed time.
    int          m_blank [NDUT] = '{2, 3};
    bit          m_hex   [NDUT] = '{1'b1, 1'b0};
    int          cyc = 0;
    int          tick_cyc [NDUT];
    bit          have_tick [NDUT];
    int          digit [NDUT];
    logic [15:0] disp [NDUT];
    logic [15:0] pend [NDUT];
    logic [3:0]  disp_dp [NDUT];
    logic [3:0]  pend_dp [NDUT];
    bit          pend_full [NDUT];
    logic [3:0]  exp_an [NDUT];
    logic [6:0]  exp_seg [NDUT];
    logic        exp_dp [NDUT];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_mis++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, expv);
        end
    endtask

    function automatic logic [6:0] model_seg(int m, int k, logic [15:0] v, bit bz);
        int nib;
        nib = (v >> (4 * k)) & 15;
        if (k > 0 && bz && (v >> (4 * k)) == 0) return 7'h7F;
        if (!m_hex[m] && nib > 9) return 7'h7F;
        return SEG_TAB[nib];
    endfunction

    task automatic model_reset();
        for (int m = 0; m < NDUT; m++) begin
            have_tick[m] = 0; tick_cyc[m] = 0; digit[m] = 3;
            disp[m] = 0; disp_dp[m] = 0; pend[m] = 0; pend_dp[m] = 0; pend_full[m] = 0;
            exp_an[m] = 4'hF; exp_seg[m] = 7'h7F; exp_dp[m] = 1'b1;
        end
    endtask

    task automatic model_edge();
        int  age;
        bit  in_blank, old_full;
        if (!Reset_n) begin
            model_reset();
        end else begin
            for (int m = 0; m < NDUT; m++) begin
                age      = cyc - tick_cyc[m];
                in_blank = have_tick[m] && age >= 1 && age <= m_blank[m];
                old_full = pend_full[m];
                if (have_tick[m] && age == m_blank[m]) begin
                    exp_an[m]  = ~(4'b0001 << digit[m]);
                    exp_seg[m] = model_seg(m, digit[m], disp[m], BlankZeros);
                    exp_dp[m]  = ~disp_dp[m][digit[m]];
                end
                if (ScanTick && !in_blank) begin
                    have_tick[m] = 1; tick_cyc[m] = cyc;
                    digit[m] = (digit[m] + 1) % 4;
                    exp_an[m] = 4'hF; exp_seg[m] = 7'h7F; exp_dp[m] = 1'b1;
                    if (digit[m] == 0 && old_full) begin
                        disp[m] = pend[m]; disp_dp[m] = pend_dp[m]; pend_full[m] = 0;
                    end
                end
                if (LoadValid && !old_full) begin
                    pend[m] = Value; pend_dp[m] = DpMask; pend_full[m] = 1;
                end
            end
        end
        cyc++;
    endtask

    task automatic check_all();
        check_val("anode0", {28'd0, an0}, {28'd0, exp_an[0]});
        check_val("seg0", {25'd0, seg0}, {25'd0, exp_seg[0]});
        check_val("dp0", {31'd0, dp0}, {31'd0, exp_dp[0]});
        check_val("ready0", {31'd0, rdy0}, {31'd0, !pend_full[0]});
        check_val("anode1", {28'd0, an1}, {28'd0, exp_an[1]});
        check_val("seg1", {25'd0, seg1}, {25'd0, exp_seg[1]});
        check_val("dp1", {31'd0, dp1}, {31'd0, exp_dp[1]});
        check_val("ready1", {31'd0, rdy1}, {31'd0, !pend_full[1]});
    endtask

    task automatic step(input bit tk, input bit lv, input logic [15:0] v, input logic [3:0] dm,
                        input bit bz, input bit rn);
        @(negedge clk);
        check_all();
        ScanTick = tk; LoadValid = lv; Value = v; DpMask = dm; BlankZeros = bz; Reset_n = rn;
        if (!rn) begin
            #1;
            check_val("async_anode0", {28'd0, an0}, 32'hF);
            check_val("async_seg0", {25'd0, seg0}, 32'h7F);
            check_val("async_ready0", {31'd0, rdy0}, 32'd1);
            check_val("async_anode1", {28'd0, an1}, 32'hF);
            check_val("async_dp1", {31'd0, dp1}, 32'd1);
        end
        @(posedge clk);
        model_edge();
    endtask

    task automatic idle(input int n, input bit bz);
        for (int i = 0; i < n; i++) step(0, 0, 16'd0, 4'd0, bz, 1);
    endtask

    task automatic frame_after_load(input logic [15:0] v, input logic [3:0] dm, input bit bz);
        step(0, 1, v, dm, bz, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 16'd0, 4'd0, bz, 1);
            idle(9, bz);
        end
    endtask

    initial begin
        logic [15:0] rv;
        model_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 16'd0, 4'd0, 0, 0);
        idle(2, 0);
        frame_after_load(16'h12AF, 4'b0000, 0);
        frame_after_load(16'h0050, 4'b0000, 1);
        frame_after_load(16'h0000, 4'b0000, 1);
        frame_after_load(16'h00C9, 4'b0010, 0);
        // Tick re-asserted on the first blanking cycle.
        step(1, 0, 16'd0, 4'd0, 0, 1);
        step(1, 0, 16'd0, 4'd0, 0, 1);
        idle(8, 0);
        // Load mid-frame, then a second offer that has to wait for the commit.
        step(1, 1, 16'h1111, 4'b0101, 0, 1);
        for (int i = 0; i < 40; i++) step((i % 10) == 0, 1, 16'h2222, 4'b1010, 0, 1);
        idle(5, 0);
        // Advance to digit 2 lit, then pulse reset without a clock edge.
        while (digit[0] != 1) begin
            step(1, 0, 16'd0, 4'd0, 0, 1);
            idle(5, 0);
        end
        step(1, 0, 16'd0, 4'd0, 0, 1);
        idle(5, 0);
        step(0, 1, 16'hABCD, 4'hF, 0, 0);
        step(0, 0, 16'd0, 4'd0, 0, 1);
        step(1, 0, 16'd0, 4'd0, 0, 1);
        idle(6, 0);
        for (int i = 0; i < 3000; i++) begin
            rv = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
            step($urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, rv, 4'($urandom),
                 ($urandom_range(0, 19) == 0) ? !BlankZeros : BlankZeros,
                 $urandom_range(0, 399) != 0);
        end
        @(negedge clk);
        check_all();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/seg_scanner.md
SEG_SCANNER -- requirements
Module: seg_scanner

Interface
REQ-001 The block SHALL have parameter BLANK_CYCLES, default 2, meaning the anode-off cycles inserted on every digit change; legal range 1..255.
REQ-002 The block SHALL have parameter HEX_MODE, default 1, meaning 1 decodes nibbles A-F and 0 renders nibbles above 9 as blank.
REQ-003 MasterClock  input  1  sole clock; all state updates on its rising edge.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 ScanTick  input  1  single-cycle strobe from the fast display clock divider; each high cycle requests the next digit.
REQ-006 Value  input  16  four nibbles to display; nibble k is shown on digit k, where digit 0 is rightmost.
REQ-007 DpMask  input  4  decimal-point enables per digit; 1 means lit.
REQ-008 BlankZeros  input  1  live leading-zero blanking enable; not latched.
REQ-009 LoadValid  input  1  Value/DpMask offer valid.
REQ-010 LoadReady  output  1  single-entry pending buffer is empty.
REQ-011 Anode  output  4  digit enables, active-low, registered.
REQ-012 Segment  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-013 Dp  output  1  decimal point, active-low, registered.

Function
REQ-014 A load SHALL be accepted on a rising edge with LoadValid=1 and LoadReady=1; Value and DpMask go to the pending buffer, and LoadReady=0 from the next cycle.
REQ-015 The pending buffer SHALL be committed to the display register only on a ScanTick that selects digit 0 (frame boundary); LoadReady returns to 1 the cycle after commit.
REQ-016 A load accepted on the same cycle as a frame-boundary tick SHALL NOT bypass to the display; it commits at the next frame boundary.
REQ-017 With LoadValid held and LoadReady=0, the offer SHALL wait; the pending contents SHALL NOT be overwritten.
REQ-018 The digit index SHALL be 2 bits, reset to 3, and advance modulo 4 on each accepted ScanTick, so the first tick after reset selects digit 0.
REQ-019 The FSM SHALL have states IDLE (post-reset, dark), BLANK and SHOW.
REQ-020 IDLE SHALL go to BLANK on ScanTick; SHOW SHALL go to BLANK on ScanTick; BLANK SHALL go to SHOW after exactly BLANK_CYCLES cycles.
REQ-021 ScanTick during BLANK SHALL be ignored: no index advance, no commit, no counter restart.
REQ-022 Timing for a tick accepted at edge N: Anode=4'b1111, Segment=7'h7F and Dp=1 during cycles N+1..N+BLANK_CYCLES, then at N+BLANK_CYCLES+1 Anode has only bit d low with digit d's segments.
REQ-023 In SHOW, outputs SHALL hold until the next accepted tick.
REQ-024 Decode SHALL be standard active-low hex: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
REQ-025 With HEX_MODE=0, nibbles 10-15 SHALL display 7'h7F.
REQ-026 With BlankZeros=1, digit k>0 SHALL show 7'h7F when nibbles k..3 of the display register are all zero; digit 0 SHALL always be decoded.
REQ-027 Dp SHALL equal ~DpMask_disp[d] in SHOW, independent of zero blanking.
REQ-028 Segment, Anode and Dp SHALL be driven only from registers.

Reset
REQ-029 Reset_n=0 SHALL immediately force Anode=4'b1111, Segment=7'h7F, Dp=1, LoadReady=1, state IDLE, index 3, display register 0, DpMask_disp 0, pending empty, blank counter 0.
REQ-030 Reset asserted mid-BLANK or mid-SHOW SHALL abort the scan, discard any pending value and keep the block dark until the first ScanTick after deassertion.

Verification
REQ-031 Reset, then load Value=16'h12AF, DpMask=4'b0000, then four ticks 10 cycles apart with BLANK_CYCLES=2 -> after the first tick, Anode=4'b1111 for 2 cycles then Anode=4'b1110, Segment=7'h0E; subsequent digits show 7'h08, 7'h24, 7'h79.
REQ-032 BlankZeros=1, Value=16'h0050 -> digits 3 and 2 show 7'h7F, digit 1 shows 7'h12, digit 0 shows 7'h40; BlankZeros=1, Value=0 -> only digit 0 is lit, showing 7'h40.
REQ-033 Load 16'h1111 while index=1, then offer 16'h2222 -> LoadReady=0, the second offer stalls, 16'h1111 appears from the digit-0 tick onward, and 16'h2222 is accepted the cycle after that commit.
REQ-034 ScanTick asserted on the first BLANK cycle -> ignored; the index advances once and SHOW begins BLANK_CYCLES cycles after the original tick.
REQ-035 Reset_n pulsed low while Anode=4'b1011 -> Anode=4'b1111 with no clock edge, LoadReady=1, and the first tick after release displays digit 0 with value 0 (7'h40).
REQ-036 HEX_MODE=0, Value=16'h00C9, DpMask=4'b0010 -> digit 1 shows 7'h7F with Dp=0, digit 0 shows 7'h10 with Dp=1.
